// File: rtl/store_wb_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_wb_buffer_pkg
// Purpose  : Shared types and constants for the retired-store write buffer.
// Revision : 1.0  initial release
// ============================================================================
package store_wb_buffer_pkg;

  localparam int c_wb_depth  = 8;  // default number of buffer entries
  localparam int c_num_lanes = 3;  // retire lanes from the store queue
  localparam int c_num_ld    = 2;  // load lookup ports

  // One retired store as it leaves the store queue
  typedef struct packed {
    logic [3:0]  usebytes;
    logic [31:0] addr;
    logic [31:0] data;
  } SQ_ENTRY_PACKET;

  // Forwarding result for one load port
  typedef struct packed {
    logic [3:0]  bytes;
    logic [31:0] data;
  } WB_FWD_PACKET;

  // Same 32-bit word: byte-offset bits are masked out rather than sliced
  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return ((a ^ b) & 32'hFFFF_FFFC) == 32'h0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_wb_buffer_fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : wb_fwd_select
// Purpose  : Per-byte youngest-match selector for one load port. Entries are
//            presented oldest first (index 0), so later matches override.
// Revision : 1.0  initial release
// ============================================================================
module wb_fwd_select
  import store_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        i_ld_valid,
  input  logic [31:0]                 i_ld_addr,
  input  SQ_ENTRY_PACKET [DEPTH-1:0]  i_age_entries,
  input  logic [DEPTH-1:0]            i_age_valid,
  output WB_FWD_PACKET                o_fwd
);

  // Walk oldest to youngest so the youngest matching byte is the one left standing
  always_comb begin
    o_fwd = '0;
    if (i_ld_valid) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (i_age_valid[k] && word_match(i_age_entries[k].addr, i_ld_addr)) begin
          for (int b = 0; b < 4; b++) begin
            if (i_age_entries[k].usebytes[b]) begin
              o_fwd.bytes[b]        = 1'b1;
              o_fwd.data[8*b +: 8]  = i_age_entries[k].data[8*b +: 8];
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/store_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_wb_buffer
// Purpose  : Retired-store write buffer. Accepts up to three stores per cycle
//            in program order, drains one per cycle to the D-cache, and
//            forwards buffered bytes to two load lookup ports.
// Revision : 1.0  initial release
// ============================================================================
module store_wb_buffer
  import store_wb_buffer_pkg::*;
#(
  parameter int WB_DEPTH = c_wb_depth,
  parameter int WB_IDX   = $clog2(WB_DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             wb_valid,
  input  SQ_ENTRY_PACKET [2:0]   cache_wb,
  output logic [WB_IDX:0]        free_slots,
  output logic                   wb_empty,
  output logic                   overflow_err,
  output logic                   dc_req_valid,
  output logic [31:0]            dc_req_addr,
  output logic [31:0]            dc_req_data,
  output logic [3:0]             dc_req_bytes,
  input  logic                   dc_req_ready,
  input  logic [1:0]             ld_valid,
  input  logic [1:0][31:0]       ld_addr,
  output logic [1:0][3:0]        ld_fwd_bytes,
  output logic [1:0][31:0]       ld_fwd_data
);

  localparam logic [WB_IDX:0] c_depth = (WB_IDX+1)'(WB_DEPTH);

  SQ_ENTRY_PACKET [WB_DEPTH-1:0] r_entries;
  logic [WB_DEPTH-1:0]           r_valid;
  logic [WB_IDX-1:0]             r_head;
  logic [WB_IDX-1:0]             r_tail;
  logic [WB_IDX:0]               r_count;
  logic [WB_IDX:0]               r_free_slots;
  logic                          r_wb_empty;
  logic                          r_overflow;

  logic [WB_IDX:0]               w_free;
  logic [2:0]                    w_lane_acc;
  logic [WB_IDX:0]               w_acc_cnt;
  logic                          w_drop;
  logic                          w_deq;
  logic [WB_IDX:0]               w_count_next;
  logic [WB_IDX-1:0]             w_lane_idx [3];
  SQ_ENTRY_PACKET                w_head_entry;
  SQ_ENTRY_PACKET [WB_DEPTH-1:0] w_age_entries;
  logic [WB_DEPTH-1:0]           w_age_valid;
  WB_FWD_PACKET                  w_fwd [2];

  // Lane acceptance against the registered count; a same-cycle drain does not make room
  always_comb begin
    w_free     = c_depth - r_count;
    w_lane_acc = '0;
    w_acc_cnt  = '0;
    for (int i = 0; i < 3; i++) begin
      w_lane_acc[i] = wb_valid[i] && (w_free > (WB_IDX+1)'(i));
      w_acc_cnt     = w_acc_cnt + {{WB_IDX{1'b0}}, w_lane_acc[i]};
      w_lane_idx[i] = r_tail + WB_IDX'(i);
    end
    w_drop       = |(wb_valid & ~w_lane_acc);
    w_deq        = dc_req_valid && dc_req_ready;
    w_count_next = r_count + w_acc_cnt - (WB_IDX+1)'(w_deq);
  end

  // Pointer, occupancy and status registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_free_slots <= c_depth;
      r_wb_empty   <= 1'b1;
      r_overflow   <= 1'b0;
    end else begin
      r_head       <= r_head + WB_IDX'(w_deq);
      r_tail       <= r_tail + w_acc_cnt[WB_IDX-1:0];
      r_count      <= w_count_next;
      r_free_slots <= c_depth - w_count_next;
      r_wb_empty   <= (w_count_next == '0);
      r_overflow   <= r_overflow | w_drop;
    end
  end

  // Entry storage: retire the head on handshake, write accepted lanes at tail onward
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_entries <= '0;
      r_valid   <= '0;
    end else begin
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (w_lane_acc[i]) begin
          r_valid[w_lane_idx[i]]   <= 1'b1;
          r_entries[w_lane_idx[i]] <= cache_wb[i];
        end
      end
    end
  end

  // Head presentation to the D-cache; fields read as zero while empty
  always_comb begin
    w_head_entry = r_entries[r_head];
    dc_req_valid = (r_count != '0);
    dc_req_addr  = dc_req_valid ? w_head_entry.addr     : 32'h0;
    dc_req_data  = dc_req_valid ? w_head_entry.data     : 32'h0;
    dc_req_bytes = dc_req_valid ? w_head_entry.usebytes : 4'h0;
  end

  assign free_slots   = r_free_slots;
  assign wb_empty     = r_wb_empty;
  assign overflow_err = r_overflow;

  // Rotate the entry array so index 0 is the oldest (head) entry
  generate
    for (genvar k = 0; k < WB_DEPTH; k++) begin : g_age
      assign w_age_entries[k] = r_entries[r_head + WB_IDX'(k)];
      assign w_age_valid[k]   = r_valid[r_head + WB_IDX'(k)];
    end
  endgenerate

  // One youngest-match selector per load port
  generate
    for (genvar p = 0; p < 2; p++) begin : g_fwd
      wb_fwd_select #(
        .DEPTH (WB_DEPTH)
      ) u_fwd_select (
        .i_ld_valid    (ld_valid[p]),
        .i_ld_addr     (ld_addr[p]),
        .i_age_entries (w_age_entries),
        .i_age_valid   (w_age_valid),
        .o_fwd         (w_fwd[p])
      );
      assign ld_fwd_bytes[p] = w_fwd[p].bytes;
      assign ld_fwd_data[p]  = w_fwd[p].data;
    end
  endgenerate

endmodule
`default_nettype wire
